seq_detect_param: RTL and testbench

//   Parametrised serial pattern detector, next generation of the fixed 4-bit detector.

---
 rtl/seq_detect_param.sv | 89 ++++++++
 tb/tb_seq_detect_param.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a run-time loadable PAT_W-bit pattern, valid qualifier,
// selectable overlapping/non-overlapping matching and a saturating match counter.
//
// state | meaning
// IDLE  | no pattern loaded, input stream ignored
// HUNT  | pattern loaded, sampling in_bit on in_valid
module seq_detect_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             armed,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, HUNT} state_t;

    state_t             state, state_n;
    logic [PAT_W-1:0]   pat_q, pat_n;
    logic [PAT_W-1:0]   hist, hist_n, hist_s;
    logic [FILL_W-1:0]  fill, fill_n, fill_s;
    logic [CNT_W-1:0]   cnt_n;
    logic               match_n;
    logic               sample;
    logic               hit;

    // load wins over a coincident valid bit, so that bit never reaches the history
    assign sample = (state == HUNT) && in_valid && !load;
    assign hist_s = {hist[PAT_W-2:0], in_bit};
    assign fill_s = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
    assign hit    = sample && (fill_s == FILL_FULL) && (hist_s == pat_q);
    assign armed  = (state == HUNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pat_q       <= '0;
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
            match       <= 1'b0;
            count_sat   <= 1'b0;
        end else begin
            state       <= state_n;
            pat_q       <= pat_n;
            hist        <= hist_n;
            fill        <= fill_n;
            match_count <= cnt_n;
            match       <= match_n;
            count_sat   <= (cnt_n == CNT_MAX);
        end
    end

    always_comb begin
        state_n = state;
        pat_n   = pat_q;
        hist_n  = hist;
        fill_n  = fill;
        cnt_n   = match_count;
        match_n = 1'b0;
        if (load) begin
            state_n = HUNT;
            pat_n   = pattern;
            hist_n  = '0;
            fill_n  = '0;
            cnt_n   = '0;
        end else if (sample) begin
            hist_n  = hist_s;
            // non-overlapping mode demands PAT_W fresh bits after every hit
            fill_n  = (hit && !overlap) ? '0 : fill_s;
            match_n = hit;
            if (hit && (match_count != CNT_MAX))
                cnt_n = match_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: vector table on a default instance,
// plus a hand-written saturation sequence on a narrow-counter instance.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, load, overlap, in_valid, in_bit;
    logic [3:0] pattern;
    logic       armed, match, count_sat;
    logic [7:0] match_count;

    logic       b_reset, b_load, b_overlap, b_valid, b_bit;
    logic [1:0] b_pattern;
    logic       b_armed, b_match, b_sat;
    logic [1:0] b_count;

    int checks = 0;
    int failures = 0;

    seq_detect_param #(.PAT_W(4), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .load(load), .pattern(pattern), .overlap(overlap),
        .in_valid(in_valid), .in_bit(in_bit), .armed(armed), .match(match),
        .match_count(match_count), .count_sat(count_sat)
    );

    seq_detect_param #(.PAT_W(2), .CNT_W(2)) dut_b (
        .clk(clk), .reset(b_reset), .load(b_load), .pattern(b_pattern), .overlap(b_overlap),
        .in_valid(b_valid), .in_bit(b_bit), .armed(b_armed), .match(b_match),
        .match_count(b_count), .count_sat(b_sat)
    );

    typedef struct {
        logic       rst;
        logic       ld;
        logic [3:0] pat;
        logic       ov;
        logic       vld;
        logic       bit_in;
        logic       e_armed;
        logic       e_match;
        logic [7:0] e_cnt;
        logic       e_sat;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic rst, logic ld, logic [3:0] pat, logic ov, logic vld,
                               logic bit_in, logic e_armed, logic e_match, logic [7:0] e_cnt,
                               string tag);
        vec_t r;
        r.rst = rst; r.ld = ld; r.pat = pat; r.ov = ov; r.vld = vld; r.bit_in = bit_in;
        r.e_armed = e_armed; r.e_match = e_match; r.e_cnt = e_cnt; r.e_sat = 1'b0; r.tag = tag;
        return r;
    endfunction

    task automatic chk(string name, int idx, int actual, int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0d exp=%0d", name, idx, actual, expected);
        end
    endtask

    // stream bits (no reset/load), overlap held at ov
    task automatic add_bits(logic [3:0] pat, logic ov, logic arm, logic [15:0] bits, int n,
                            logic [15:0] hits, int cnt_start, string tag);
        int cnt = cnt_start;
        for (int i = 0; i < n; i++) begin
            logic b, h;
            b = bits[n-1-i];
            h = hits[n-1-i];
            if (h) cnt++;
            vecs.push_back(v(0, 0, pat, ov, 1, b, arm, h, 8'(cnt), tag));
        end
    endtask

    task automatic step_b(logic rst, logic ld, logic vld, logic bit_in);
        @(negedge clk);
        b_reset = rst; b_load = ld; b_valid = vld; b_bit = bit_in;
        b_pattern = 2'b11; b_overlap = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; load = 0; pattern = 0; overlap = 0; in_valid = 0; in_bit = 0;
        b_reset = 1; b_load = 0; b_pattern = 0; b_overlap = 1; b_valid = 0; b_bit = 0;

        // reset state
        vecs.push_back(v(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, "reset"));
        // no pattern loaded: stream is ignored
        add_bits(4'b1011, 0, 0, 16'b1011_1011, 8, 16'h0, 0, "idle_stream");
        // non-overlapping detect of 1011 in 1011_0000_1011_0000
        vecs.push_back(v(0, 1, 4'b1011, 0, 0, 0, 1, 0, 0, "load1"));
        add_bits(4'b1011, 0, 1, 16'b1011_0000_1011_0000, 16,
                 16'b0001_0000_0001_0000, 0, "t1");
        // pattern 1010, overlapping; reload clears the count
        vecs.push_back(v(0, 1, 4'b1010, 1, 0, 0, 1, 0, 0, "load2a"));
        add_bits(4'b1010, 1, 1, 16'b101010, 6, 16'b000101, 0, "t2_ov");
        vecs.push_back(v(0, 1, 4'b1010, 0, 0, 0, 1, 0, 0, "load2b"));
        add_bits(4'b1010, 0, 1, 16'b101010, 6, 16'b000100, 0, "t2_nov");
        // gapped valid: three idle cycles (with toggling in_bit) between samples
        vecs.push_back(v(0, 1, 4'b1011, 0, 0, 0, 1, 0, 0, "load3"));
        vecs.push_back(v(0, 0, 4'b1011, 0, 1, 1, 1, 0, 0, "t3_b1"));
        for (int g = 0; g < 3; g++) vecs.push_back(v(0, 0, 4'b1011, 0, 0, g[0], 1, 0, 0, "t3_gap"));
        vecs.push_back(v(0, 0, 4'b1011, 0, 1, 0, 1, 0, 0, "t3_b2"));
        for (int g = 0; g < 3; g++) vecs.push_back(v(0, 0, 4'b1011, 0, 0, 1, 1, 0, 0, "t3_gap"));
        vecs.push_back(v(0, 0, 4'b1011, 0, 1, 1, 1, 0, 0, "t3_b3"));
        for (int g = 0; g < 3; g++) vecs.push_back(v(0, 0, 4'b1011, 0, 0, 0, 1, 0, 0, "t3_gap"));
        vecs.push_back(v(0, 0, 4'b1011, 0, 1, 1, 1, 1, 1, "t3_b4"));
        vecs.push_back(v(0, 0, 4'b1011, 0, 0, 1, 1, 0, 1, "t3_after"));
        // reset mid-stream, bits ignored until reload, load beats a coincident valid bit
        vecs.push_back(v(0, 1, 4'b1011, 0, 0, 0, 1, 0, 0, "load5"));
        add_bits(4'b1011, 0, 1, 16'b101, 3, 16'h0, 0, "t5_pre");
        vecs.push_back(v(1, 0, 4'b1011, 0, 1, 1, 0, 0, 0, "t5_rst"));
        add_bits(4'b1011, 0, 0, 16'b1011, 4, 16'h0, 0, "t5_dead");
        vecs.push_back(v(0, 1, 4'b1011, 0, 1, 1, 1, 0, 0, "t5_ld_vld"));
        add_bits(4'b1011, 0, 1, 16'b011_1011, 7, 16'b000_0001, 0, "t5_post");

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; load = vecs[i].ld; pattern = vecs[i].pat;
            overlap = vecs[i].ov; in_valid = vecs[i].vld; in_bit = vecs[i].bit_in;
            @(posedge clk);
            #1;
            chk({vecs[i].tag, ".armed"}, i, int'(armed), int'(vecs[i].e_armed));
            chk({vecs[i].tag, ".match"}, i, int'(match), int'(vecs[i].e_match));
            chk({vecs[i].tag, ".count"}, i, int'(match_count), int'(vecs[i].e_cnt));
            chk({vecs[i].tag, ".sat"}, i, int'(count_sat), int'(vecs[i].e_sat));
        end

        // narrow counter saturation: pattern 11, overlapping, seven 1s
        begin
            int exp_cnt[7] = '{0, 1, 2, 3, 3, 3, 3};
            step_b(1, 0, 0, 0);
            chk("b_reset.count", 0, int'(b_count), 0);
            step_b(0, 1, 0, 0);
            chk("b_load.armed", 0, int'(b_armed), 1);
            for (int i = 0; i < 7; i++) begin
                step_b(0, 0, 1, 1);
                chk("b_sat.match", i, int'(b_match), (i == 0) ? 0 : 1);
                chk("b_sat.count", i, int'(b_count), exp_cnt[i]);
                chk("b_sat.sat", i, int'(b_sat), (i >= 3) ? 1 : 0);
            end
            step_b(0, 0, 0, 1);
            chk("b_hold.match", 0, int'(b_match), 0);
            chk("b_hold.count", 0, int'(b_count), 3);
            step_b(0, 1, 0, 0);
            chk("b_reload.count", 0, int'(b_count), 0);
            chk("b_reload.sat", 0, int'(b_sat), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
